hazard_ctrl_seq: RTL and testbench

Sequential, parametrised hazard controller for the five-stage RISC-V pipeline. It drives stall/flush for all five stage registers and per-operand forwarding selects. Over the purely combinational hazard unit it adds N source operands, a multi-cycle load-use bubble counter, full-pipe freeze on data-cache miss, and a kill state that discards wrong-path fetches returning after an instruction-cache miss.

---
 rtl/hazard_ctrl_seq_if.sv | 40 ++++
 rtl/hazard_ctrl_seq.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_seq_if.sv
// Hazard controller pipeline bundle: hazard inputs from the pipeline, stall/flush/forward outputs back.
// master = pipeline side (drives hazard inputs), slave = hazard controller.
interface hazard_ctrl_seq_if #(
  parameter int AW   = 5,
  parameter int NSRC = 2
);
  logic                 ICacheMiss;
  logic                 DCacheMiss;
  logic                 BranchE;
  logic                 JalrE;
  logic                 JalD;
  logic [NSRC*AW-1:0]   RsD;
  logic [NSRC*AW-1:0]   RsE;
  logic [NSRC-1:0]      RegReadD;
  logic [NSRC-1:0]      RegReadE;
  logic [AW-1:0]        RdE;
  logic [AW-1:0]        RdM;
  logic [AW-1:0]        RdW;
  logic                 MemToRegE;
  logic [2:0]           RegWriteM;
  logic [2:0]           RegWriteW;
  logic                 StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic                 StallM, FlushM, StallW, FlushW;
  logic [2*NSRC-1:0]    Forward;
  logic [1:0]           HzdState;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, RsD, RsE, RegReadD, RegReadE,
           RdE, RdM, RdW, MemToRegE, RegWriteM, RegWriteW,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
           Forward, HzdState
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, RsD, RsE, RegReadD, RegReadE,
           RdE, RdM, RdW, MemToRegE, RegWriteM, RegWriteW,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
           Forward, HzdState
  );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// Sequential five-stage hazard controller: forwarding, multi-cycle load-use bubbles, D-cache freeze, wrong-path kill.
// Optional HZD_PERF_CNT_EN adds StallCycles/KillCycles performance counters.
module hazard_ctrl_seq #(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int LD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 CpuRst,
  hazard_ctrl_seq_if.slave     hz
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [31:0]          StallCycles,
  output logic [31:0]          KillCycles
`endif
);
  localparam int CW = $clog2(LD_LAT) + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_KILL    = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic [2*NSRC-1:0] w_fwd;
  logic [NSRC-1:0]   w_lu_src;
  logic              w_lu_hit;
  logic              w_redirect;
  logic              w_stall_f, w_flush_f, w_stall_d, w_flush_d, w_stall_e, w_flush_e;
  logic              w_stall_m, w_flush_m, w_stall_w, w_flush_w;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [AW-1:0] w_rse;
      logic [AW-1:0] w_rsd;
      logic          w_hit_m;
      logic          w_hit_w;
      assign w_rse   = hz.RsE[AW*gi +: AW];
      assign w_rsd   = hz.RsD[AW*gi +: AW];
      assign w_hit_m = hz.RegReadE[gi] && (hz.RegWriteM != 3'd0) && (hz.RdM == w_rse) && (w_rse != '0);
      assign w_hit_w = hz.RegReadE[gi] && (hz.RegWriteW != 3'd0) && (hz.RdW == w_rse) && (w_rse != '0);
      // M holds the younger result, so it wins over W
      assign w_fwd[2*gi +: 2] = w_hit_m ? 2'b10 : (w_hit_w ? 2'b01 : 2'b00);
      assign w_lu_src[gi]     = hz.RegReadD[gi] && (w_rsd == hz.RdE);
    end
  endgenerate

  assign w_lu_hit   = hz.MemToRegE && (hz.RdE != '0) && (|w_lu_src);
  assign w_redirect = hz.BranchE | hz.JalrE;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall_f = 1'b0; w_flush_f = 1'b0; w_stall_d = 1'b0; w_flush_d = 1'b0;
    w_stall_e = 1'b0; w_flush_e = 1'b0; w_stall_m = 1'b0; w_flush_m = 1'b0;
    w_stall_w = 1'b0; w_flush_w = 1'b0;
    if (CpuRst) begin
      w_flush_f = 1'b1; w_flush_d = 1'b1; w_flush_e = 1'b1; w_flush_m = 1'b1; w_flush_w = 1'b1;
    end else if (hz.DCacheMiss) begin
      w_stall_f = 1'b1; w_stall_d = 1'b1; w_stall_e = 1'b1; w_stall_m = 1'b1; w_flush_w = 1'b1;
    end else if (w_redirect) begin
      // an outstanding I-miss refill is wrong-path, so it must be killed on return
      w_flush_d    = 1'b1;
      w_flush_e    = 1'b1;
      w_cnt_next   = '0;
      w_state_next = (r_state == ST_KILL || hz.ICacheMiss) ? ST_KILL : ST_RUN;
    end else if (r_state == ST_KILL) begin
      w_flush_d = 1'b1;
      w_stall_f = hz.ICacheMiss;
      if (!hz.ICacheMiss) w_state_next = ST_RUN;
    end else if (r_state == ST_LDSTALL && r_cnt != '0) begin
      w_stall_f  = 1'b1;
      w_stall_d  = 1'b1;
      w_flush_e  = 1'b1;
      w_cnt_next = r_cnt - CW'(1);
      if (r_cnt == CW'(1)) w_state_next = ST_RUN;
    end else begin
      w_state_next = ST_RUN;
      if (w_lu_hit) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
        if (LD_LAT > 1) begin
          w_state_next = ST_LDSTALL;
          w_cnt_next   = CW'(LD_LAT - 1);
        end
      end else begin
        w_flush_d = hz.JalD | hz.ICacheMiss;
        w_stall_f = hz.ICacheMiss;
      end
    end
  end

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (!hz.DCacheMiss) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign hz.StallF   = w_stall_f;
  assign hz.FlushF   = w_flush_f;
  assign hz.StallD   = w_stall_d;
  assign hz.FlushD   = w_flush_d;
  assign hz.StallE   = w_stall_e;
  assign hz.FlushE   = w_flush_e;
  assign hz.StallM   = w_stall_m;
  assign hz.FlushM   = w_flush_m;
  assign hz.StallW   = w_stall_w;
  assign hz.FlushW   = w_flush_w;
  assign hz.Forward  = CpuRst ? '0 : w_fwd;
  assign hz.HzdState = r_state;

`ifdef HZD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_kill_cycles;

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      r_stall_cycles <= '0;
      r_kill_cycles  <= '0;
    end else begin
      if (w_stall_f) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_state == ST_KILL) r_kill_cycles <= r_kill_cycles + 32'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign KillCycles  = r_kill_cycles;
`endif
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Self-checking bench for hazard_ctrl_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl_seq;
  localparam int AW     = 5;
  localparam int NSRC   = 2;
  localparam int LD_LAT = 3;

  // stall/flush vector order: {SF,FF,SD,FD,SE,FE,SM,FM,SW,FW}
  localparam logic [9:0] V_NONE  = 10'b0000000000;
  localparam logic [9:0] V_RST   = 10'b0101010101;
  localparam logic [9:0] V_DMISS = 10'b1010101001;
  localparam logic [9:0] V_BUB   = 10'b1010010000;
  localparam logic [9:0] V_REDIR = 10'b0001010000;
  localparam logic [9:0] V_KILLM = 10'b1001000000;
  localparam logic [9:0] V_KILL  = 10'b0001000000;

  logic clk = 1'b0;
  logic CpuRst;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctrl_seq_if #(.AW(AW), .NSRC(NSRC)) hzif ();

`ifdef HZD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] KillCycles;
`endif

  hazard_ctrl_seq #(.AW(AW), .NSRC(NSRC), .LD_LAT(LD_LAT)) dut (
    .clk        (clk),
    .CpuRst     (CpuRst),
    .hz         (hzif)
`ifdef HZD_PERF_CNT_EN
    ,
    .StallCycles(StallCycles),
    .KillCycles (KillCycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] sf_now();
    return {hzif.StallF, hzif.FlushF, hzif.StallD, hzif.FlushD, hzif.StallE,
            hzif.FlushE, hzif.StallM, hzif.FlushM, hzif.StallW, hzif.FlushW};
  endfunction

  task automatic clear_inputs();
    hzif.ICacheMiss = 1'b0; hzif.DCacheMiss = 1'b0;
    hzif.BranchE = 1'b0; hzif.JalrE = 1'b0; hzif.JalD = 1'b0;
    hzif.RsD = '0; hzif.RsE = '0; hzif.RegReadD = '0; hzif.RegReadE = '0;
    hzif.RdE = '0; hzif.RdM = '0; hzif.RdW = '0; hzif.MemToRegE = 1'b0;
    hzif.RegWriteM = '0; hzif.RegWriteW = '0;
  endtask

  task automatic set_load_use();
    hzif.MemToRegE = 1'b1; hzif.RdE = 5'd7;
    hzif.RsD = {5'd7, 5'd3}; hzif.RegReadD = 2'b10;
  endtask

  task automatic test_reset();
    CpuRst = 1'b1;
    hzif.RsE = {5'd5, 5'd5}; hzif.RegReadE = 2'b11; hzif.RdM = 5'd5; hzif.RegWriteM = 3'd1;
    hzif.DCacheMiss = 1'b1; hzif.BranchE = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_RST) begin n_errors++; $display("FAIL reset_sf: got %b want %b", sf_now(), V_RST); end
    n_checks++;
    if (hzif.Forward !== 4'b0000) begin n_errors++; $display("FAIL reset_fwd: got %b want 0000", hzif.Forward); end
    n_checks++;
    if (hzif.HzdState !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b want 00", hzif.HzdState); end
`ifdef HZD_PERF_CNT_EN
    n_checks++;
    if (StallCycles !== 32'd0) begin n_errors++; $display("FAIL reset_stallcyc: got %0d want 0", StallCycles); end
`endif
    @(posedge clk); #1;
    CpuRst = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_NONE) begin n_errors++; $display("FAIL post_reset_sf: got %b want %b", sf_now(), V_NONE); end
    $display("test_reset done: sf=%b state=%b", sf_now(), hzif.HzdState);
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    hzif.RsE = {5'd5, 5'd5}; hzif.RegReadE = 2'b11;
    hzif.RdM = 5'd5; hzif.RegWriteM = 3'd1; hzif.RdW = 5'd5; hzif.RegWriteW = 3'd1;
    #1;
    n_checks++;
    if (hzif.Forward !== 4'b1010) begin n_errors++; $display("FAIL fwd_m_wins: got %b want 1010", hzif.Forward); end
    hzif.RsE = {5'd5, 5'd0};
    #1;
    n_checks++;
    if (hzif.Forward !== 4'b1000) begin n_errors++; $display("FAIL fwd_x0: got %b want 1000", hzif.Forward); end
    hzif.RsE = {5'd5, 5'd5}; hzif.RegWriteM = 3'd0;
    #1;
    n_checks++;
    if (hzif.Forward !== 4'b0101) begin n_errors++; $display("FAIL fwd_w_only: got %b want 0101", hzif.Forward); end
    hzif.RegWriteM = 3'b100; hzif.RegReadE = 2'b01; hzif.RdW = 5'd6;
    #1;
    n_checks++;
    if (hzif.Forward !== 4'b0010) begin n_errors++; $display("FAIL fwd_regread: got %b want 0010", hzif.Forward); end
    $display("test_forwarding done: fwd=%b", hzif.Forward);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [1:0] exp_st [3] = '{2'b00, 2'b01, 2'b01};
    set_load_use();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (sf_now() !== V_BUB) begin n_errors++; $display("FAIL lu_bubble%0d: got %b want %b", k, sf_now(), V_BUB); end
      n_checks++;
      if (hzif.HzdState !== exp_st[k]) begin n_errors++; $display("FAIL lu_state%0d: got %b want %b", k, hzif.HzdState, exp_st[k]); end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_NONE || hzif.HzdState !== 2'b00) begin
      n_errors++; $display("FAIL lu_done: got sf=%b st=%b want sf=%b st=00", sf_now(), hzif.HzdState, V_NONE);
    end
    @(posedge clk); #1;
    set_load_use();
    hzif.RegReadD = 2'b00;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_NONE) begin n_errors++; $display("FAIL lu_unused: got %b want %b", sf_now(), V_NONE); end
    @(posedge clk); #1;
    n_checks++;
    if (hzif.HzdState !== 2'b00) begin n_errors++; $display("FAIL lu_unused_state: got %b want 00", hzif.HzdState); end
    $display("test_load_use done: state=%b", hzif.HzdState);
    clear_inputs();
  endtask

  task automatic test_redirect_cancel();
    set_load_use();
    hzif.BranchE = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_REDIR) begin n_errors++; $display("FAIL redir_sf: got %b want %b", sf_now(), V_REDIR); end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (hzif.HzdState !== 2'b00 || sf_now() !== V_NONE) begin
      n_errors++; $display("FAIL redir_next: got st=%b sf=%b want st=00 sf=%b", hzif.HzdState, sf_now(), V_NONE);
    end
    @(posedge clk); #1;
    set_load_use();
    @(posedge clk); #1;
    hzif.JalrE = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_REDIR) begin n_errors++; $display("FAIL redir_mid_sf: got %b want %b", sf_now(), V_REDIR); end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (hzif.HzdState !== 2'b00) begin n_errors++; $display("FAIL redir_mid_state: got %b want 00", hzif.HzdState); end
    $display("test_redirect_cancel done: state=%b", hzif.HzdState);
    @(posedge clk); #1;
  endtask

  task automatic test_kill();
    hzif.ICacheMiss = 1'b1; hzif.JalrE = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_REDIR) begin n_errors++; $display("FAIL kill_enter_sf: got %b want %b", sf_now(), V_REDIR); end
    @(posedge clk); #1;
    hzif.JalrE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (sf_now() !== V_KILLM || hzif.HzdState !== 2'b10) begin
        n_errors++; $display("FAIL kill_miss%0d: got sf=%b st=%b want sf=%b st=10", k, sf_now(), hzif.HzdState, V_KILLM);
      end
      @(posedge clk); #1;
    end
    hzif.ICacheMiss = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_KILL || hzif.HzdState !== 2'b10) begin
      n_errors++; $display("FAIL kill_return: got sf=%b st=%b want sf=%b st=10", sf_now(), hzif.HzdState, V_KILL);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_NONE || hzif.HzdState !== 2'b00) begin
      n_errors++; $display("FAIL kill_exit: got sf=%b st=%b want sf=%b st=00", sf_now(), hzif.HzdState, V_NONE);
    end
    $display("test_kill done: state=%b", hzif.HzdState);
    @(posedge clk); #1;
  endtask

  task automatic test_dcache_freeze();
    set_load_use();
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_BUB) begin n_errors++; $display("FAIL dc_first_bub: got %b want %b", sf_now(), V_BUB); end
    @(posedge clk); #1;
    hzif.DCacheMiss = 1'b1;
    hzif.BranchE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (sf_now() !== V_DMISS || hzif.HzdState !== 2'b01) begin
        n_errors++; $display("FAIL dc_freeze%0d: got sf=%b st=%b want sf=%b st=01", k, sf_now(), hzif.HzdState, V_DMISS);
      end
      @(posedge clk); #1;
    end
    hzif.DCacheMiss = 1'b0;
    hzif.BranchE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (sf_now() !== V_BUB || hzif.HzdState !== 2'b01) begin
        n_errors++; $display("FAIL dc_resume%0d: got sf=%b st=%b want sf=%b st=01", k, sf_now(), hzif.HzdState, V_BUB);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (sf_now() !== V_NONE || hzif.HzdState !== 2'b00) begin
      n_errors++; $display("FAIL dc_done: got sf=%b st=%b want sf=%b st=00", sf_now(), hzif.HzdState, V_NONE);
    end
    $display("test_dcache_freeze done: state=%b", hzif.HzdState);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_kill();
    hzif.ICacheMiss = 1'b1; hzif.BranchE = 1'b1;
    @(posedge clk); #1;
    hzif.BranchE = 1'b0;
    CpuRst = 1'b1;
    #1;
    n_checks++;
    if (sf_now() !== V_RST || hzif.HzdState !== 2'b00) begin
      n_errors++; $display("FAIL rst_kill: got sf=%b st=%b want sf=%b st=00", sf_now(), hzif.HzdState, V_RST);
    end
    @(negedge clk);
    CpuRst = 1'b0;
    #1;
    n_checks++;
    if (sf_now() !== V_KILLM || hzif.HzdState !== 2'b00) begin
      n_errors++; $display("FAIL rst_kill_release: got sf=%b st=%b want sf=%b st=00", sf_now(), hzif.HzdState, V_KILLM);
    end
    @(posedge clk); #1;
    n_checks++;
    if (hzif.HzdState !== 2'b00) begin n_errors++; $display("FAIL rst_kill_after: got %b want 00", hzif.HzdState); end
    $display("test_reset_mid_kill done: state=%b", hzif.HzdState);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int ncyc);
    bit          m_kill = 1'b0;
    int          m_owed = 0;
    bit          ic_sticky = 1'b0;
    logic [31:0] m_stall_cyc = '0;
    logic [31:0] m_kill_cyc = '0;
    for (int c = 0; c < ncyc; c++) begin
      logic [9:0]        exp_sf;
      logic [2*NSRC-1:0] exp_fwd;
      logic [1:0]        exp_st;
      bit                rst_v;
      bit                hit;
      rst_v = (c == 0) || ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) ic_sticky = ~ic_sticky;
      CpuRst          = rst_v;
      hzif.ICacheMiss = ic_sticky;
      hzif.DCacheMiss = ($urandom_range(0, 7) == 0);
      hzif.BranchE    = ($urandom_range(0, 9) == 0);
      hzif.JalrE      = ($urandom_range(0, 11) == 0);
      hzif.JalD       = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NSRC; i++) begin
        hzif.RsD[AW*i +: AW] = AW'($urandom_range(0, 3));
        hzif.RsE[AW*i +: AW] = AW'($urandom_range(0, 3));
      end
      hzif.RegReadD  = NSRC'($urandom);
      hzif.RegReadE  = NSRC'($urandom);
      hzif.RdE       = AW'($urandom_range(0, 3));
      hzif.RdM       = AW'($urandom_range(0, 3));
      hzif.RdW       = AW'($urandom_range(0, 3));
      hzif.MemToRegE = ($urandom_range(0, 2) == 0);
      hzif.RegWriteM = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      hzif.RegWriteW = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      @(negedge clk);

      if (rst_v) begin m_kill = 1'b0; m_owed = 0; end
      exp_st = m_kill ? 2'b10 : ((m_owed > 0) ? 2'b01 : 2'b00);

      exp_fwd = '0;
      hit = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        logic [AW-1:0] rse;
        logic [AW-1:0] rsd;
        rse = hzif.RsE[AW*i +: AW];
        rsd = hzif.RsD[AW*i +: AW];
        if (!rst_v && hzif.RegReadE[i] && rse != 0) begin
          if (hzif.RegWriteM != 0 && hzif.RdM == rse) exp_fwd[2*i +: 2] = 2'b10;
          else if (hzif.RegWriteW != 0 && hzif.RdW == rse) exp_fwd[2*i +: 2] = 2'b01;
        end
        if (hzif.RegReadD[i] && rsd == hzif.RdE) hit = 1'b1;
      end
      hit = hit && hzif.MemToRegE && (hzif.RdE != 0);

      if (rst_v) begin
        exp_sf = V_RST;
      end else if (hzif.DCacheMiss) begin
        exp_sf = V_DMISS;
      end else if (hzif.BranchE || hzif.JalrE) begin
        exp_sf = V_REDIR;
        m_owed = 0;
        m_kill = m_kill || hzif.ICacheMiss;
      end else if (m_kill) begin
        exp_sf = hzif.ICacheMiss ? V_KILLM : V_KILL;
        if (!hzif.ICacheMiss) m_kill = 1'b0;
      end else if (m_owed > 0) begin
        exp_sf = V_BUB;
        m_owed--;
      end else if (hit) begin
        exp_sf = V_BUB;
        m_owed = LD_LAT - 1;
      end else begin
        exp_sf = V_NONE;
        exp_sf[6] = hzif.JalD || hzif.ICacheMiss;
        exp_sf[9] = hzif.ICacheMiss;
      end

      n_checks++;
      if (sf_now() !== exp_sf) begin n_errors++; $display("FAIL rnd_sf c%0d: got %b want %b", c, sf_now(), exp_sf); end
      n_checks++;
      if (hzif.Forward !== exp_fwd) begin n_errors++; $display("FAIL rnd_fwd c%0d: got %b want %b", c, hzif.Forward, exp_fwd); end
      n_checks++;
      if (hzif.HzdState !== exp_st) begin n_errors++; $display("FAIL rnd_state c%0d: got %b want %b", c, hzif.HzdState, exp_st); end
      $display("rnd c%0d rst=%0d sf=%b fwd=%b st=%b", c, rst_v, sf_now(), hzif.Forward, hzif.HzdState);

      if (rst_v) begin
        m_stall_cyc = '0;
        m_kill_cyc  = '0;
      end else begin
        m_stall_cyc = m_stall_cyc + 32'(exp_sf[9]);
        m_kill_cyc  = m_kill_cyc + 32'(exp_st == 2'b10);
      end
      @(posedge clk); #1;
    end
    CpuRst = 1'b0;
    clear_inputs();
`ifdef HZD_PERF_CNT_EN
    n_checks++;
    if (StallCycles !== m_stall_cyc) begin n_errors++; $display("FAIL rnd_stallcyc: got %0d want %0d", StallCycles, m_stall_cyc); end
    n_checks++;
    if (KillCycles !== m_kill_cyc) begin n_errors++; $display("FAIL rnd_killcyc: got %0d want %0d", KillCycles, m_kill_cyc); end
`else
    if (m_stall_cyc == 32'hFFFF_FFFF && m_kill_cyc == 32'hFFFF_FFFF) $display("rnd counters saturated");
`endif
    $display("test_random done: %0d cycles", ncyc);
  endtask

  initial begin
    clear_inputs();
    CpuRst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_cancel();
    test_kill();
    test_dcache_freeze();
    test_reset_mid_kill();
    test_random(300);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
